// File: rtl/card_hand_datapath.sv
// Card-hand datapath: answers the round controller's one-hot load strobes with cards,
// holds both hands, scores them and flags out-of-order loads.
module card_hand_datapath #(
  parameter int CARD_SEED = 1
) (
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       force_en,
  input  logic [3:0] force_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       seq_error
);

  typedef enum logic [2:0] {IDLE, P1, D1, P2, D2, P3, DONE} phase_t;

  // Slot order: 0=pcard1 1=dcard1 2=pcard2 3=dcard2 4=pcard3 5=dcard3 (deal order).
  logic [3:0] slot_q [6];
  logic [3:0] slot_d [6];
  logic [3:0] gen_q, gen_d;
  logic       err_q, err_d;
  phase_t     phase_q, phase_d;

  logic [5:0] ld;
  logic [3:0] card;
  logic       card_ok;
  logic       legal;
  logic       capture;

  assign ld      = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
  assign card    = force_en ? force_card : gen_q;
  assign card_ok = (card >= 4'd1) && (card <= 4'd13);

  // State register for the deal tracker.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) phase_q <= IDLE;
    else         phase_q <= phase_d;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      gen_q <= 4'(CARD_SEED);
      err_q <= 1'b0;
      for (int i = 0; i < 6; i++) slot_q[i] <= 4'd0;
    end else begin
      gen_q <= gen_d;
      err_q <= err_d;
      for (int i = 0; i < 6; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Next-state: legality of the single strobe against the phase of the last card.
  always_comb begin
    legal   = 1'b0;
    phase_d = phase_q;
    unique case (ld)
      6'b000001: begin legal = 1'b1;                            phase_d = P1;   end
      6'b000010: begin legal = (phase_q == P1);                 phase_d = D1;   end
      6'b000100: begin legal = (phase_q == D1);                 phase_d = P2;   end
      6'b001000: begin legal = (phase_q == P2);                 phase_d = D2;   end
      6'b010000: begin legal = (phase_q == D2);                 phase_d = P3;   end
      6'b100000: begin legal = (phase_q == D2) || (phase_q == P3); phase_d = DONE; end
      default:   begin legal = 1'b0;                            phase_d = phase_q; end
    endcase
    capture = legal && card_ok;
    if (!capture) phase_d = phase_q;

    gen_d = (gen_q == 4'd13) ? 4'd1 : gen_q + 4'd1;
    err_d = err_q | ((|ld) && !capture);

    for (int i = 0; i < 6; i++) begin
      slot_d[i] = slot_q[i];
      // A restart empties every slot in the same edge it writes pcard1.
      if (capture && ld[0]) slot_d[i] = 4'd0;
      if (capture && ld[i]) slot_d[i] = card;
    end
  end

  function automatic logic [4:0] card_val(input logic [3:0] c);
    return (c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    if (s >= 5'd20)      return 4'(s - 5'd20);
    else if (s >= 5'd10) return 4'(s - 5'd10);
    else                 return s[3:0];
  endfunction

  logic [4:0] psum, dsum;

  always_comb begin
    psum      = card_val(slot_q[0]) + card_val(slot_q[2]) + card_val(slot_q[4]);
    dsum      = card_val(slot_q[1]) + card_val(slot_q[3]) + card_val(slot_q[5]);
    pscore    = mod10(psum);
    dscore    = mod10(dsum);
    pcard1    = slot_q[0];
    dcard1    = slot_q[1];
    pcard2    = slot_q[2];
    dcard2    = slot_q[3];
    pcard3    = slot_q[4];
    dcard3    = slot_q[5];
    seq_error = err_q;
  end

endmodule

// File: tb/tb_card_hand_datapath.sv
// Table-driven bench for card_hand_datapath with a scoreboard queue of expected outputs;
// hand-written sequences cover asynchronous reset mid-hand and generator reseed.
module tb_card_hand_datapath;

  localparam logic [5:0] NL  = 6'd0;
  localparam logic [5:0] LP1 = 6'b000001;
  localparam logic [5:0] LD1 = 6'b000010;
  localparam logic [5:0] LP2 = 6'b000100;
  localparam logic [5:0] LD2 = 6'b001000;
  localparam logic [5:0] LP3 = 6'b010000;
  localparam logic [5:0] LD3 = 6'b100000;

  typedef struct {
    logic [5:0] ld;
    logic       fe;
    logic [3:0] fc;
    logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds;
    logic       err;
  } vec_t;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       load_pcard1 = 0, load_pcard2 = 0, load_pcard3 = 0;
  logic       load_dcard1 = 0, load_dcard2 = 0, load_dcard3 = 0;
  logic       force_en = 1'b0;
  logic [3:0] force_card = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
  logic       seq_error;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  card_hand_datapath #(.CARD_SEED(12)) dut (
    .slow_clock(slow_clock), .resetb(resetb),
    .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
    .force_en(force_en), .force_card(force_card),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .seq_error(seq_error)
  );

  always #5 slow_clock = ~slow_clock;

  function automatic vec_t mk(input logic [5:0] ld, input logic fe, input logic [3:0] fc,
                              input logic [3:0] p1, p2, p3, d1, d2, d3, ps, ds,
                              input logic err);
    vec_t v;
    v.ld = ld; v.fe = fe; v.fc = fc;
    v.p1 = p1; v.p2 = p2; v.p3 = p3; v.d1 = d1; v.d2 = d2; v.d3 = d3;
    v.ps = ps; v.ds = ds; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic check_outputs(input vec_t e, input string tag);
    chk({tag, " pcard1"}, pcard1, e.p1);
    chk({tag, " pcard2"}, pcard2, e.p2);
    chk({tag, " pcard3"}, pcard3, e.p3);
    chk({tag, " dcard1"}, dcard1, e.d1);
    chk({tag, " dcard2"}, dcard2, e.d2);
    chk({tag, " dcard3"}, dcard3, e.d3);
    chk({tag, " pscore"}, pscore, e.ps);
    chk({tag, " dscore"}, dscore, e.ds);
    chk({tag, " seq_error"}, seq_error, e.err);
  endtask

  task automatic set_loads(input logic [5:0] ld);
    load_pcard1 = ld[0]; load_dcard1 = ld[1]; load_pcard2 = ld[2];
    load_dcard2 = ld[3]; load_pcard3 = ld[4]; load_dcard3 = ld[5];
  endtask

  // Drive one transaction (caller is between edges), compare 1 time unit after the edge.
  task automatic drive(input vec_t v, input string tag);
    vec_t e;
    set_loads(v.ld);
    force_en   = v.fe;
    force_card = v.fc;
    exp_q.push_back(v);
    @(posedge slow_clock);
    #1;
    e = exp_q.pop_front();
    check_outputs(e, tag);
    $display("%s ld=%b fe=%0d fc=%0d -> P %0d %0d %0d D %0d %0d %0d ps=%0d ds=%0d err=%0d",
             tag, v.ld, v.fe, v.fc, pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
             pscore, dscore, seq_error);
    @(negedge slow_clock);
    set_loads(NL);
  endtask

  initial begin
    vec_t z;
    z = mk(NL, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Generator: seed 12, idle edge, then 13 and wrap to 1.
    tbl.push_back(mk(NL,  0, 0,   0, 0, 0,   0, 0, 0,   0, 0, 0));
    tbl.push_back(mk(LP1, 0, 0,  13, 0, 0,   0, 0, 0,   0, 0, 0));
    tbl.push_back(mk(LD1, 0, 0,  13, 0, 0,   1, 0, 0,   0, 1, 0));
    // Full forced deal.
    tbl.push_back(mk(LP1, 1, 9,   9, 0, 0,   0, 0, 0,   9, 0, 0));
    tbl.push_back(mk(LD1, 1, 13,  9, 0, 0,  13, 0, 0,   9, 0, 0));
    tbl.push_back(mk(LP2, 1, 5,   9, 5, 0,  13, 0, 0,   4, 0, 0));
    tbl.push_back(mk(LD2, 1, 2,   9, 5, 0,  13, 2, 0,   4, 2, 0));
    tbl.push_back(mk(LP3, 1, 8,   9, 5, 8,  13, 2, 0,   2, 2, 0));
    tbl.push_back(mk(LD3, 1, 7,   9, 5, 8,  13, 2, 7,   2, 9, 0));
    tbl.push_back(mk(NL,  1, 3,   9, 5, 8,  13, 2, 7,   2, 9, 0));
    // Second hand, restart after P3.
    tbl.push_back(mk(LP1, 1, 3,   3, 0, 0,   0, 0, 0,   3, 0, 0));
    tbl.push_back(mk(LD1, 1, 4,   3, 0, 0,   4, 0, 0,   3, 4, 0));
    tbl.push_back(mk(LP2, 1, 1,   3, 1, 0,   4, 0, 0,   4, 4, 0));
    tbl.push_back(mk(LD2, 1, 2,   3, 1, 0,   4, 2, 0,   4, 6, 0));
    tbl.push_back(mk(LP3, 1, 5,   3, 1, 5,   4, 2, 0,   9, 6, 0));
    tbl.push_back(mk(LP1, 1, 6,   6, 0, 0,   0, 0, 0,   6, 0, 0));
    tbl.push_back(mk(LD1, 1, 11,  6, 0, 0,  11, 0, 0,   6, 0, 0));
    tbl.push_back(mk(LP2, 1, 9,   6, 9, 0,  11, 0, 0,   5, 0, 0));
    tbl.push_back(mk(LD2, 1, 8,   6, 9, 0,  11, 8, 0,   5, 8, 0));
    // Dealer draws while player stands.
    tbl.push_back(mk(LD3, 1, 10,  6, 9, 0,  11, 8, 10,  5, 8, 0));
    // Violations and sticky error.
    tbl.push_back(mk(LP1, 1, 7,   7, 0, 0,   0, 0, 0,   7, 0, 0));
    tbl.push_back(mk(LP2, 1, 2,   7, 0, 0,   0, 0, 0,   7, 0, 1));
    tbl.push_back(mk(LP1|LD1, 1, 4, 7, 0, 0, 0, 0, 0,   7, 0, 1));
    tbl.push_back(mk(LD1, 1, 9,   7, 0, 0,   9, 0, 0,   7, 9, 1));
    tbl.push_back(mk(LP1, 1, 5,   5, 0, 0,   0, 0, 0,   5, 0, 1));
    tbl.push_back(mk(LD1, 1, 2,   5, 0, 0,   2, 0, 0,   5, 2, 1));
    tbl.push_back(mk(LP2, 1, 0,   5, 0, 0,   2, 0, 0,   5, 2, 1));
    tbl.push_back(mk(LP2, 1, 14,  5, 0, 0,   2, 0, 0,   5, 2, 1));
    tbl.push_back(mk(LP2, 1, 15,  5, 0, 0,   2, 0, 0,   5, 2, 1));
    tbl.push_back(mk(LP2, 1, 4,   5, 4, 0,   2, 0, 0,   9, 2, 1));
    tbl.push_back(mk(LP3, 1, 7,   5, 4, 0,   2, 0, 0,   9, 2, 1));
    tbl.push_back(mk(LD3, 1, 7,   5, 4, 0,   2, 0, 0,   9, 2, 1));
    tbl.push_back(mk(LD2, 1, 3,   5, 4, 0,   2, 3, 0,   9, 5, 1));
    tbl.push_back(mk(LD2, 1, 6,   5, 4, 0,   2, 3, 0,   9, 5, 1));
    tbl.push_back(mk(6'b111111, 1, 1, 5, 4, 0, 2, 3, 0, 9, 5, 1));
    tbl.push_back(mk(LP3, 1, 9,   5, 4, 9,   2, 3, 0,   8, 5, 1));
    tbl.push_back(mk(LD3, 1, 9,   5, 4, 9,   2, 3, 9,   8, 4, 1));
    // All nines: sums up to 27.
    tbl.push_back(mk(LP1, 1, 9,   9, 0, 0,   0, 0, 0,   9, 0, 1));
    tbl.push_back(mk(LD1, 1, 9,   9, 0, 0,   9, 0, 0,   9, 9, 1));
    tbl.push_back(mk(LP2, 1, 9,   9, 9, 0,   9, 0, 0,   8, 9, 1));
    tbl.push_back(mk(LD2, 1, 9,   9, 9, 0,   9, 9, 0,   8, 8, 1));
    tbl.push_back(mk(LP3, 1, 9,   9, 9, 9,   9, 9, 0,   7, 8, 1));
    tbl.push_back(mk(LD3, 1, 9,   9, 9, 9,   9, 9, 9,   7, 7, 1));

    // Reset state with clock running.
    repeat (2) @(posedge slow_clock);
    #1;
    check_outputs(z, "reset");
    $display("reset: all slots %0d %0d %0d %0d %0d %0d err=%0d",
             pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, seq_error);
    @(negedge slow_clock);
    resetb = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i], $sformatf("vec%0d", i));

    // Reset mid-hand, asserted between edges.
    drive(mk(LP1, 1, 3,  3, 0, 0,  0, 0, 0,  3, 0, 1), "mid_p1");
    drive(mk(LD1, 1, 4,  3, 0, 0,  4, 0, 0,  3, 4, 1), "mid_d1");
    drive(mk(LP2, 1, 5,  3, 5, 0,  4, 0, 0,  8, 4, 1), "mid_p2");
    drive(mk(LD2, 1, 6,  3, 5, 0,  4, 6, 0,  8, 0, 1), "mid_d2");
    #2;
    resetb = 1'b0;
    #1;
    check_outputs(z, "async_rst");
    $display("async_rst: P %0d %0d %0d D %0d %0d %0d ps=%0d ds=%0d err=%0d",
             pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore, seq_error);
    set_loads(LP1);
    force_card = 4'd8;
    @(posedge slow_clock);
    #1;
    check_outputs(z, "rst_held");
    $display("rst_held: pcard1=%0d err=%0d", pcard1, seq_error);
    @(negedge slow_clock);
    set_loads(NL);
    resetb = 1'b1;

    // First edge after release is normal; generator restarts from the seed.
    drive(mk(LP1, 1, 2,  2, 0, 0,  0, 0, 0,  2, 0, 0), "post_p1");
    drive(mk(LD3, 1, 2,  2, 0, 0,  0, 0, 0,  2, 0, 1), "post_bad_d3");
    drive(mk(LP1, 0, 0,  1, 0, 0,  0, 0, 0,  1, 0, 1), "post_gen");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
